// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES types and GF(2^8) helpers used by the decryption datapath.
//   state_t      : 16-byte AES state, byte 0 first; column c is bytes 4c..4c+3
//   column_t     : one 4-byte column, row 0 first
//   GF_POLY      : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   xtime()      : multiply a field element by x (i.e. by 8'h02)
//   imc_state_t  : control states of the iterative InvMixColumns unit
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [0:15][7:0] state_t;
    typedef logic [0:3][7:0]  column_t;

    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } imc_state_t;

    // Multiply by x in GF(2^8): shift left and fold the overflow bit back
    // in with the reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column_seq_col.sv
// ---------------------------------------------------------------------------
// inv_mix_single_column
// Combinational InvMixColumns for a single AES column.
//   col_in  : input column a0..a3 (row 0 first)
//   col_out : output column b0..b3
// Every constant multiplier is formed from the chain x2 = xtime(a),
// x4 = xtime(x2), x8 = xtime(x4):
//   09 = x8^a, 0b = x8^x2^a, 0d = x8^x4^a, 0e = x8^x4^x2
// ---------------------------------------------------------------------------
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [0:3][7:0] col_in,
    output logic [0:3][7:0] col_out
);

    logic [0:3][7:0] m09;
    logic [0:3][7:0] m0b;
    logic [0:3][7:0] m0d;
    logic [0:3][7:0] m0e;

    // Per-byte multiples by 09, 0b, 0d and 0e built from the xtime chain.
    for (genvar i = 0; i < 4; i++) begin : g_mul
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;

        assign x2     = xtime(col_in[i]);
        assign x4     = xtime(x2);
        assign x8     = xtime(x4);
        assign m09[i] = x8 ^ col_in[i];
        assign m0b[i] = x8 ^ x2 ^ col_in[i];
        assign m0d[i] = x8 ^ x4 ^ col_in[i];
        assign m0e[i] = x8 ^ x4 ^ x2;
    end

    // The inverse matrix is circulant: row r applies 0e,0b,0d,09 starting
    // at byte r and wrapping around the column.
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign col_out[r] = m0e[r] ^ m0b[(r + 1) % 4] ^ m0d[(r + 2) % 4] ^ m09[(r + 3) % 4];
    end

endmodule

// File: rtl/inv_mix_column_seq.sv
// ---------------------------------------------------------------------------
// inv_mix_column_seq
// Iterative AES InvMixColumns. A state is captured on start, then
// COLS_PER_CYCLE columns per clock are run through shared single-column
// datapaths. The completed state appears on state_array_out together with
// a one-cycle done pulse and is held until the next completion.
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   start           : request, only looked at while idle
//   state_array_in  : state to transform, sampled on the accepting edge
//   busy            : high while a block is in flight (CALC and DONE)
//   done            : one-cycle completion pulse
//   state_array_out : last completed result
// ---------------------------------------------------------------------------
module inv_mix_column_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [0:15][7:0]  state_array_in,
    output logic              busy,
    output logic              done,
    output logic [0:15][7:0]  state_array_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("inv_mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // With four lanes the step wraps the 2-bit counter to zero, which is
    // harmless because the first group is also the last one.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    imc_state_t state_q;
    imc_state_t state_d;
    logic [1:0] col_q;
    state_t     in_reg;
    state_t     work_reg;
    state_t     work_next;
    column_t    mix_in  [COLS_PER_CYCLE];
    column_t    mix_out [COLS_PER_CYCLE];
    logic       last_group;

    assign last_group = (col_q == LAST_COL);

    // One datapath lane per column handled in a cycle; lane g picks column
    // col_q+g out of the captured input state.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        logic [1:0] col_idx;

        assign col_idx   = col_q + 2'(g);
        assign mix_in[g] = in_reg[{col_idx, 2'b00} +: 4];

        inv_mix_single_column u_col (
            .col_in  (mix_in[g]),
            .col_out (mix_out[g])
        );
    end

    // Merge this cycle's lane results into a copy of the working register so
    // the completion edge can publish a state that already contains the
    // final group.
    always_comb begin
        work_next = work_reg;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            for (int r = 0; r < 4; r++) begin
                work_next[{col_q + 2'(g), 2'(r)}] = mix_out[g][r];
            end
        end
    end

    // State register for the control FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step through the column groups in
    // CALC, spend exactly one cycle in DONE. A start seen outside IDLE is
    // simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_group) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers. The input is captured only on the accepting edge,
    // and the output register moves only on the completion edge, so partial
    // results never reach state_array_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg          <= '0;
            work_reg        <= '0;
            col_q           <= '0;
            state_array_out <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_reg <= state_array_in;
                        col_q  <= '0;
                    end
                end
                CALC: begin
                    work_reg <= work_next;
                    col_q    <= col_q + COL_STEP;
                    if (last_group) begin
                        state_array_out <= work_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_column_seq
// Self-checking bench for inv_mix_column_seq. Three instances run side by
// side with COLS_PER_CYCLE = 1, 2 and 4 (instance k has 4>>k groups).
// Expected results come from a field-arithmetic reference model
// (carry-less multiply plus polynomial reduction applied through the
// circulant matrices), never from the design.
// ---------------------------------------------------------------------------
module tb_inv_mix_column_seq;
    import aes_pkg::*;

    typedef struct {
        state_t stim;
        state_t expect_out;
    } vec_t;

    logic   clk;
    logic   rst;
    logic   start_v [3];
    state_t din_v   [3];
    logic   busy_v  [3];
    logic   done_v  [3];
    state_t dout_v  [3];

    int checks;
    int failures;

    inv_mix_column_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .start           (start_v[0]),
        .state_array_in  (din_v[0]),
        .busy            (busy_v[0]),
        .done            (done_v[0]),
        .state_array_out (dout_v[0])
    );

    inv_mix_column_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk             (clk),
        .rst             (rst),
        .start           (start_v[1]),
        .state_array_in  (din_v[1]),
        .busy            (busy_v[1]),
        .done            (done_v[1]),
        .state_array_out (dout_v[1])
    );

    inv_mix_column_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .start           (start_v[2]),
        .state_array_in  (din_v[2]),
        .busy            (busy_v[2]),
        .done            (done_v[2]),
        .state_array_out (dout_v[2])
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain GF(2^8) product: carry-less multiply, then reduce by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        end
        return p[7:0];
    endfunction

    // Apply a circulant matrix whose first row is c0..c3 to every column.
    function automatic state_t matMix(input state_t s, input logic [7:0] c0, input logic [7:0] c1,
                                      input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] cf [4];
        state_t     o;
        cf[0] = c0; cf[1] = c1; cf[2] = c2; cf[3] = c3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    o[4*c+r] = o[4*c+r] ^ gmul(cf[(k - r + 4) % 4], s[4*c+k]);
                end
            end
        end
        return o;
    endfunction

    function automatic state_t refInv(input state_t s);
        return matMix(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic state_t refFwd(input state_t s);
        return matMix(s, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    function automatic state_t randState();
        state_t s;
        for (int i = 0; i < 16; i++) s[i] = 8'($urandom_range(0, 255));
        return s;
    endfunction

    task automatic checkOutput(input string name, input int k, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst=C%0d got=%0h expected=%0h", name, 1 << k, act, exp);
        end
    endtask

    // One transaction on all three instances: start pulse with s at edge 0,
    // then watch cycles after edges 0..8. With press set, start is held with
    // state alt through every busy edge (CALC and DONE) and must be ignored.
    task automatic applyStimulus(input state_t s, input state_t exp, input bit press,
                                 input state_t alt, input string tag);
        int     first_d [3];
        int     pulses  [3];
        bit     busy_ok [3];
        bit     hold_ok [3];
        state_t prev    [3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b1;
            din_v[k]   = s;
            prev[k]    = dout_v[k];
            first_d[k] = -1;
            pulses[k]  = 0;
            busy_ok[k] = 1'b1;
            hold_ok[k] = 1'b1;
        end
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int n;
                n = 4 >> k;
                if (busy_v[k] !== (c <= n)) busy_ok[k] = 1'b0;
                if (c < n && dout_v[k] !== prev[k]) hold_ok[k] = 1'b0;
                if (done_v[k] === 1'b1) begin
                    pulses[k]++;
                    if (first_d[k] < 0) first_d[k] = c;
                end
                start_v[k] = press && (c + 1 <= n + 1);
                din_v[k]   = alt;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, " done_edge"}, k, 128'(first_d[k]), 128'(4 >> k));
            checkOutput({tag, " done_pulses"}, k, 128'(pulses[k]), 128'd1);
            checkOutput({tag, " busy_window"}, k, 128'(busy_ok[k]), 128'd1);
            checkOutput({tag, " out_held"}, k, 128'(hold_ok[k]), 128'd1);
            checkOutput({tag, " result"}, k, dout_v[k], exp);
        end
    endtask

    initial begin
        vec_t   vecs [$];
        vec_t   v;
        state_t s;
        int     times [3][$];

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            din_v[k]   = '0;
        end

        // Vector table: the known AES columns plus two random states.
        v.stim = 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc;
        v.expect_out = 128'hdb135345_db135345_db135345_db135345;
        vecs.push_back(v);
        v.stim = 128'h9fdc589d_d5d5d7d6_4d7ebdf8_01010101;
        v.expect_out = 128'hf20a225c_d4d4d4d5_2d26314c_01010101;
        vecs.push_back(v);
        for (int i = 0; i < 2; i++) begin
            v.stim = randState();
            v.expect_out = refInv(v.stim);
            vecs.push_back(v);
        end

        // Reset for two cycles, then the reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset busy", k, 128'(busy_v[k]), 128'd0);
            checkOutput("reset done", k, 128'(done_v[k]), 128'd0);
            checkOutput("reset out", k, dout_v[k], 128'd0);
        end

        $display("[TB] table vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stim, vecs[i].expect_out, 1'b0, randState(), "table");
        end

        $display("[TB] start while busy");
        s = randState();
        applyStimulus(s, refInv(s), 1'b1, randState(), "busy_start");

        $display("[TB] reset mid-operation");
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b1;
            din_v[k]   = randState();
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("midreset busy", k, 128'(busy_v[k]), 128'd0);
            checkOutput("midreset done", k, 128'(done_v[k]), 128'd0);
            checkOutput("midreset out", k, dout_v[k], 128'd0);
        end
        applyStimulus(vecs[1].stim, vecs[1].expect_out, 1'b0, randState(), "after_reset");

        $display("[TB] back-to-back with start held");
        s = randState();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b1;
            din_v[k]   = s;
        end
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done_v[k] === 1'b1) times[k].push_back(c);
            end
        end
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int n;
            bit ok;
            n  = 4 >> k;
            ok = (times[k].size() >= 3);
            foreach (times[k][i]) begin
                if (times[k][i] != n + i * (n + 2)) ok = 1'b0;
            end
            checkOutput("b2b period", k, 128'(ok), 128'd1);
            checkOutput("b2b result", k, dout_v[k], refInv(s));
            checkOutput("b2b idle", k, 128'(busy_v[k]), 128'd0);
        end

        $display("[TB] random round trip");
        for (int i = 0; i < 1000; i++) begin
            s = randState();
            applyStimulus(refFwd(s), s, 1'b0, randState(), "roundtrip");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_mix_column_seq.md
Name: inv_mix_column_seq

Overview:
- Iterative AES InvMixColumns unit for the decryption datapath; the inverse of the combinational forward mix_column stage.
- Accepts a 128-bit state on a start pulse and processes COLS_PER_CYCLE columns per clock through a shared single-column GF(2^8) inverse datapath.
- Presents the full result with a one-cycle done pulse, trading latency for area against a fully unrolled inverse.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- state_array_in  input  [0:15][7:0]  input state; column c is bytes 4c..4c+3, byte 4c is row 0.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; result valid.
- state_array_out  output  [0:15][7:0]  result, held until the next completion.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE, busy=0, done=0, state_array_out=0, working register=0, column counter=0. Reset has priority over every other event, including mid-operation; any partial result is discarded.
- States:
  - IDLE: start=1 at an edge captures state_array_in into the input register, clears the counter, and goes to CALC.
  - CALC: each edge transforms columns col..col+COLS_PER_CYCLE-1 into the working register and advances col by COLS_PER_CYCLE. The final group goes to DONE and copies the completed working register, including the final group, to state_array_out on the same edge.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: N = 4/COLS_PER_CYCLE. If start is sampled at edge 0, done is high in the cycle after edge N. Throughput is one block per N+2 cycles.
- busy=1 in CALC and DONE, 0 in IDLE.
- start while busy is ignored, not queued. start in the DONE cycle is ignored. start held high in IDLE re-triggers immediately after returning to IDLE.
- state_array_in is sampled only at the accepting edge; later changes have no effect.
- state_array_out changes only on the completion edge or reset; partial columns are never visible.
- Arithmetic, per column a0..a3 to b0..b3:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1. It is built only from xtime: shift left 1, XOR 8'h1B if the old bit 7 was 1. Constants come from chained xtime: x2, x4, x8, then XOR combinations. No lookup tables. All intermediates are 8 bits.
- Counter width is 2 bits; wrap-around after column 3 is never used for addressing.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t = logic [0:15][7:0]
  - typedef column_t = logic [0:3][7:0]
  - localparam GF_POLY = 8'h1B
  - function xtime
  - enum imc_state_t {IDLE, CALC, DONE}
- Sub-module inv_mix_single_column: combinational, column_t in and column_t out. Instantiated COLS_PER_CYCLE times with an index mux on the input register and a demux into the working register.

Test Plan:
- Reset, then a column: rst=1 for 2 cycles, then columns {8e,4d,a1,bc}×4 with start pulse -> busy=1; done high in the cycle after edge 4 (COLS_PER_CYCLE=1); out columns all {db,13,53,45}; out=0 before completion.
- Mixed columns: cols {9f,dc,58,9d},{d5,d5,d7,d6},{4d,7e,bd,f8},{01,01,01,01} -> {f2,0a,22,5c},{d4,d4,d4,d5},{2d,26,31,4c},{01,01,01,01}. Run for COLS_PER_CYCLE=1,2,4, expecting done after 4, 2, 1 edges respectively.
- start while busy: second start with a different state at edges 1–5 -> ignored; single done pulse; first result retained.
- Reset mid-operation: rst at edge 2 of CALC -> next cycle busy=0, done=0, out=0; a new start then completes normally.
- Back-to-back and round trip:
  - start held high -> completions every 6 cycles.
  - 1000 random states passed through mix_column then this block -> output equals the original state.
